// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: shares the register-file write port between writeback and JAL link writes,
// buffering up to two link writes that lose arbitration to writeback.
module regwrite_arbiter #(
    parameter int LINK_REG = 31,
    parameter int AGE_WB   = 3
) (
    input  logic        Clk_in,
    input  logic        Rst_n,
    input  logic        WB_RegWrite_in,
    input  logic [4:0]  WB_WriteRegister_in,
    input  logic [31:0] WB_WriteData_in,
    input  logic        Link_Req_in,
    input  logic [31:0] Link_Data_in,
    output logic        RegWrite_out,
    output logic [4:0]  WriteRegister_out,
    output logic [31:0] WriteData_out,
    output logic        Stall_out,
    output logic [1:0]  Pending_out
);
    logic [31:0] data0_q, data0_d, data1_q, data1_d;
    logic [2:0]  age0_q, age0_d, age1_q, age1_d;
    logic [1:0]  cnt_q, cnt_d, n_keep;
    logic        wb_act, pop, bypass, push, sup, keep0, keep1;

    function automatic logic [2:0] age_inc(input logic [2:0] a);
        return (a == 3'd7) ? a : a + 3'd1;
    endfunction

    always_comb begin
        wb_act = WB_RegWrite_in && (WB_WriteRegister_in != 5'd0);
        pop    = !wb_act && (cnt_q != 2'd0);
        bypass = !wb_act && (cnt_q == 2'd0) && Link_Req_in;
        push   = Link_Req_in && !bypass && ((cnt_q != 2'd2) || pop);
        sup    = wb_act && (WB_WriteRegister_in == 5'(LINK_REG));
        // Entries older than the writeback's travel time belong to older JALs than the writer
        keep0  = (cnt_q != 2'd0) && !pop && !(sup && (age0_q > 3'(AGE_WB)));
        keep1  = (cnt_q == 2'd2) && !(sup && (age1_q > 3'(AGE_WB)));
        n_keep = {1'b0, keep0} + {1'b0, keep1};
        data0_d = keep0 ? data0_q : data1_q;
        age0_d  = age_inc(keep0 ? age0_q : age1_q);
        data1_d = data1_q;
        age1_d  = age_inc(age1_q);
        if (push) begin
            if (n_keep == 2'd0) begin
                data0_d = Link_Data_in;
                age0_d  = 3'd0;
            end else begin
                data1_d = Link_Data_in;
                age1_d  = 3'd0;
            end
        end
        cnt_d = n_keep + {1'b0, push};
    end

    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            data0_q <= '0;
            data1_q <= '0;
            age0_q  <= '0;
            age1_q  <= '0;
            cnt_q   <= '0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            age0_q  <= age0_d;
            age1_q  <= age1_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by Rst_n so they clear immediately while reset is held
    assign RegWrite_out      = Rst_n && (wb_act || pop || bypass);
    assign WriteRegister_out = !Rst_n ? 5'd0 : wb_act ? WB_WriteRegister_in :
                               (pop || bypass) ? 5'(LINK_REG) : 5'd0;
    assign WriteData_out     = !Rst_n ? 32'd0 : wb_act ? WB_WriteData_in :
                               pop ? data0_q : bypass ? Link_Data_in : 32'd0;
    assign Stall_out         = Rst_n && (cnt_q == 2'd2) && !pop;
    assign Pending_out       = cnt_q;
endmodule

// File: tb/tb_regwrite_arbiter.sv
// tb_regwrite_arbiter: directed checks of arbitration, buffering, stall, supersede and reset.
module tb_regwrite_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        l_req;
    logic [31:0] l_data;
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        stall;
    logic [1:0]  pend;
    int total = 0;
    int bad = 0;

    regwrite_arbiter dut (
        .Clk_in(clk), .Rst_n(rst_n),
        .WB_RegWrite_in(wb_we), .WB_WriteRegister_in(wb_reg), .WB_WriteData_in(wb_data),
        .Link_Req_in(l_req), .Link_Data_in(l_data),
        .RegWrite_out(rw), .WriteRegister_out(wr), .WriteData_out(wd),
        .Stall_out(stall), .Pending_out(pend)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic [4:0] r, input logic [31:0] d,
                         input logic lr, input logic [31:0] ld);
        wb_we = we; wb_reg = r; wb_data = d; l_req = lr; l_data = ld;
        #1;
    endtask

    task automatic chk(input string tag, input logic e_rw, input logic [4:0] e_wr,
                       input logic [31:0] e_wd, input logic e_st, input logic [1:0] e_pd);
        total += 5;
        assert (rw === e_rw) else begin bad++; $error("FAIL %s.rw got %b exp %b", tag, rw, e_rw); end
        assert (wr === e_wr) else begin bad++; $error("FAIL %s.wr got %0d exp %0d", tag, wr, e_wr); end
        assert (wd === e_wd) else begin bad++; $error("FAIL %s.wd got %h exp %h", tag, wd, e_wd); end
        assert (stall === e_st) else begin bad++; $error("FAIL %s.stall got %b exp %b", tag, stall, e_st); end
        assert (pend === e_pd) else begin bad++; $error("FAIL %s.pend got %0d exp %0d", tag, pend, e_pd); end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1, 5'd5, 32'h1234, 1, 32'h99);
        chk("reset", 0, 0, 0, 0, 0);
        tick;
        chk("reset_held", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        chk("idle", 0, 0, 0, 0, 0);
        tick;
        // bypass
        drive(0, 0, 0, 1, 32'h00400010);
        chk("bypass", 1, 31, 32'h00400010, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0);
        chk("bypass_after", 0, 0, 0, 0, 0);
        tick;
        // conflict
        drive(1, 5'd5, 32'hDEADBEEF, 1, 32'h44);
        chk("conf_wb", 1, 5, 32'hDEADBEEF, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0);
        chk("conf_link", 1, 31, 32'h44, 0, 1);
        tick;
        chk("conf_empty", 0, 0, 0, 0, 0);
        // full / stall
        drive(1, 5'd6, 32'h600, 1, 32'hA1);
        chk("full_c0", 1, 6, 32'h600, 0, 0);
        tick;
        drive(1, 5'd6, 32'h601, 1, 32'hA2);
        chk("full_c1", 1, 6, 32'h601, 0, 1);
        tick;
        drive(1, 5'd6, 32'h602, 1, 32'hA3);
        chk("full_c2", 1, 6, 32'h602, 1, 2);
        tick;
        drive(1, 5'd6, 32'h603, 1, 32'hA3);
        chk("full_c3", 1, 6, 32'h603, 1, 2);
        tick;
        drive(0, 0, 0, 1, 32'hA3);
        chk("full_poppush", 1, 31, 32'hA1, 0, 2);
        tick;
        drive(0, 0, 0, 0, 0);
        chk("full_drain1", 1, 31, 32'hA2, 0, 2);
        tick;
        chk("full_drain2", 1, 31, 32'hA3, 0, 1);
        tick;
        chk("full_empty", 0, 0, 0, 0, 0);
        // supersede: entry age 4 at the r31 writeback
        drive(1, 5'd5, 32'h1, 1, 32'h100);
        chk("sup_c0", 1, 5, 32'h1, 0, 0);
        tick;
        drive(1, 5'd5, 32'h1, 0, 0);
        for (int i = 0; i < 4; i++) tick;
        chk("sup_c4", 1, 5, 32'h1, 0, 1);
        drive(1, 5'd31, 32'h200, 0, 0);
        chk("sup_wb31", 1, 31, 32'h200, 0, 1);
        tick;
        drive(0, 0, 0, 0, 0);
        chk("sup_gone", 0, 0, 0, 0, 0);
        tick;
        // boundary retain: entry age exactly AGE_WB
        drive(1, 5'd5, 32'h1, 1, 32'h100);
        tick;
        drive(1, 5'd5, 32'h1, 0, 0);
        for (int i = 0; i < 3; i++) tick;
        drive(1, 5'd31, 32'h250, 0, 0);
        chk("age3_wb31", 1, 31, 32'h250, 0, 1);
        tick;
        drive(0, 0, 0, 0, 0);
        chk("age3_kept", 1, 31, 32'h100, 0, 1);
        tick;
        // retain: r31 writeback 2 cycles after push
        drive(1, 5'd5, 32'h1, 1, 32'h100);
        tick;
        drive(1, 5'd5, 32'h1, 0, 0);
        tick;
        drive(1, 5'd31, 32'h300, 0, 0);
        chk("ret_wb31", 1, 31, 32'h300, 0, 1);
        tick;
        drive(0, 0, 0, 0, 0);
        chk("ret_link", 1, 31, 32'h100, 0, 1);
        tick;
        chk("ret_empty", 0, 0, 0, 0, 0);
        // reset mid-operation
        drive(1, 5'd5, 32'h1, 1, 32'hB1);
        tick;
        drive(1, 5'd5, 32'h2, 1, 32'hB2);
        tick;
        drive(1, 5'd5, 32'h3, 1, 32'hB3);
        chk("rst_full", 1, 5, 32'h3, 1, 2);
        rst_n = 1'b0;
        #1;
        chk("rst_async", 0, 0, 0, 0, 0);
        tick;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        chk("rst_after", 0, 0, 0, 0, 0);
        tick;
        chk("rst_after2", 0, 0, 0, 0, 0);
        // zero register is no request
        drive(1, 5'd0, 32'hFFFF, 1, 32'h8);
        chk("zero_reg", 1, 31, 32'h8, 0, 0);
        tick;
        drive(0, 0, 0, 0, 0);
        chk("zero_after", 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 The block SHALL have ports:
  Clk_in  input  1  pipeline clock, rising edge;
  Rst_n  input  1  asynchronous active-low reset;
  WB_RegWrite_in  input  1  writeback-stage write request;
  WB_WriteRegister_in  input  5  writeback destination register;
  WB_WriteData_in  input  32  writeback data;
  Link_Req_in  input  1  JAL link-write request from decode (destination fixed at r31);
  Link_Data_in  input  32  link value (PC+4) from decode;
  RegWrite_out  output  1  register-file write enable;
  WriteRegister_out  output  5  register-file write address;
  WriteData_out  output  32  register-file write data;
  Stall_out  output  1  link buffer full, decode must hold;
  Pending_out  output  2  number of buffered link writes, 0..2.
REQ-002 Parameter LINK_REG, default 31: the link destination register.
REQ-003 Parameter AGE_WB, default 3: the number of cycles a JAL takes to travel from decode to writeback.

Function
REQ-004 The block SHALL arbitrate the single register-file write port between writeback and link writes; the write port output is combinational, and the buffer state is registered.
REQ-005 Priority: writeback, then buffer head, then a new link request bypassing the buffer.
REQ-006 WB_RegWrite_in=1 with WB_WriteRegister_in!=0 SHALL drive RegWrite_out=1 with the writeback address and data in the same cycle.
REQ-007 WB_RegWrite_in=1 with WB_WriteRegister_in=0 SHALL be treated as no request, and the port SHALL be offered to lower priorities.
REQ-008 The link buffer SHALL be a 2-entry FIFO; each entry SHALL hold 32-bit data and a 3-bit age counter that saturates at 7.
REQ-009 Each cycle, every valid entry's age SHALL increment by 1, saturating.
REQ-010 With writeback idle and the buffer non-empty, the head SHALL be written to LINK_REG and popped at the clock edge.
REQ-011 With writeback idle, the buffer empty and Link_Req_in=1, the link SHALL be written directly with zero latency and SHALL NOT be buffered.
REQ-012 When Link_Req_in=1 and the request is not bypassed, it SHALL be accepted into the tail with age 0 only if the occupancy is below 2 or a pop occurs in the same cycle.
REQ-013 Stall_out SHALL equal (occupancy==2 AND no pop this cycle).
REQ-014 Link_Req_in while Stall_out=1 SHALL NOT be accepted; the requester SHALL hold its request.
REQ-015 Supersede rule: a writeback to LINK_REG SHALL discard, at the edge, every buffered entry whose age is greater than AGE_WB, because that writeback is from a younger instruction.
REQ-016 Entries with age at most AGE_WB SHALL be retained under the supersede rule.
REQ-017 Simultaneous push, pop and supersede SHALL resolve in this order: discard, then pop, then push; the FIFO order of survivors SHALL be preserved.
REQ-018 Pending_out SHALL equal the registered occupancy.
REQ-019 With no request, RegWrite_out SHALL be 0, WriteRegister_out SHALL be 0 and WriteData_out SHALL be 0.
REQ-020 Occupancy SHALL never exceed 2 or underflow below 0, under any input sequence.

Reset
REQ-021 While Rst_n=0, asynchronously, all entries SHALL be invalid, occupancy SHALL be 0, and all ages SHALL be 0.
REQ-022 While Rst_n=0, all outputs SHALL be 0, including Stall_out=0 and Pending_out=0.
REQ-023 Reset asserted mid-operation SHALL discard buffered links without any write.
REQ-024 Operation SHALL resume on the first rising edge after Rst_n deasserts.

Verification
REQ-025 Bypass: the buffer is empty, writeback is idle, and Link_Req_in=1 with data 0x00400010. The same cycle SHALL show RegWrite_out=1, WriteRegister_out=31, WriteData_out=0x00400010, and Pending_out SHALL stay 0.
REQ-026 Conflict: WB writes r5=0xDEADBEEF while a link with data 0x44 arrives. The first cycle SHALL write r5. The next idle cycle SHALL write r31=0x44. Pending_out SHALL go 1 then 0.
REQ-027 Full/stall: writeback is busy for 4 cycles while 3 link requests are held. Pending_out SHALL reach 2, Stall_out=1, and the third request SHALL be held. On the first idle cycle, a pop and a push SHALL occur together, Stall_out=0, and Pending_out SHALL stay 2.
REQ-028 Supersede: link 0x100 is buffered and writeback stays busy for 5 cycles. WB then writes r31=0x200. The entry SHALL be discarded, Pending_out=0, and r31 SHALL never be written with 0x100.
REQ-029 Retain: link 0x100 is buffered, and 2 cycles later WB writes r31=0x300. The entry SHALL be retained, and the next idle cycle SHALL write r31=0x100.
REQ-030 Reset mid-op: Rst_n is pulled low with Pending_out=2. Outputs SHALL go to 0 immediately. After release, with no requests, RegWrite_out SHALL stay 0.
REQ-031 Zero register: WB with WriteRegister_in=0 together with a link 0x8 in the same cycle. The link SHALL be bypassed to r31 that cycle.
